// File: rtl/mips_cpu_core.sv
// Single-cycle MIPS-32 subset core with a minimal CP0 (SR/Cause/EPC) for precise
// exceptions and one external interrupt. Memories are external and combinational.
module mips_cpu_core #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        interrupt,
  output logic [31:0] macroscopic_pc,
  output logic [31:0] i_inst_addr,
  input  logic [31:0] i_inst_rdata,
  output logic [31:0] m_data_addr,
  input  logic [31:0] m_data_rdata,
  output logic [31:0] m_data_wdata,
  output logic [3:0]  m_data_byteen,
  output logic [31:0] m_int_addr,
  output logic [3:0]  m_int_byteen,
  output logic [31:0] m_inst_addr,
  output logic        w_grf_we,
  output logic [4:0]  w_grf_addr,
  output logic [31:0] w_grf_wdata,
  output logic [31:0] w_inst_addr
);
  logic [31:0] pc_q, pc_d, sr_q, epc_q;
  logic [4:0]  exc_q;
  logic        ip_q;
  logic [31:0] grf_q [32];

  logic [5:0]  op, fn;
  logic [4:0]  rs, rt, rd, sa;
  logic [31:0] simm, zimm, rs_v, rt_v, pc4, maddr, cp0_rd;
  logic signed [31:0] opa_s, opb_s, sum_s, dif_s;

  function automatic logic add_ov(input logic signed [31:0] a, b, s);
    return (a[31] == b[31]) && (s[31] != a[31]);
  endfunction

  function automatic logic sub_ov(input logic signed [31:0] a, b, d);
    return (a[31] != b[31]) && (d[31] != a[31]);
  endfunction

  assign op    = i_inst_rdata[31:26];
  assign rs    = i_inst_rdata[25:21];
  assign rt    = i_inst_rdata[20:16];
  assign rd    = i_inst_rdata[15:11];
  assign sa    = i_inst_rdata[10:6];
  assign fn    = i_inst_rdata[5:0];
  assign simm  = {{16{i_inst_rdata[15]}}, i_inst_rdata[15:0]};
  assign zimm  = {16'h0, i_inst_rdata[15:0]};
  assign rs_v  = grf_q[rs];
  assign rt_v  = grf_q[rt];
  assign pc4   = pc_q + 32'd4;
  assign maddr = rs_v + simm;
  assign opa_s = rs_v;
  assign opb_s = (op == 6'h00) ? rt_v : simm;
  assign sum_s = opa_s + opb_s;
  assign dif_s = opa_s - opb_s;

  always_comb begin
    cp0_rd = 32'h0;
    case (rd)
      5'd12:   cp0_rd = sr_q;
      5'd13:   cp0_rd = {16'h0, 5'h0, ip_q, 3'h0, exc_q, 2'h0};
      5'd14:   cp0_rd = epc_q;
      default: cp0_rd = 32'h0;
    endcase
  end

  logic        wr_en, ri, sysc, ov, ld, st, mtc0, eret;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data, npc;
  logic [1:0]  sz;

  always_comb begin
    wr_en = 1'b0; wr_addr = rt; wr_data = 32'h0; npc = pc4;
    ri = 1'b0; sysc = 1'b0; ov = 1'b0; ld = 1'b0; st = 1'b0;
    mtc0 = 1'b0; eret = 1'b0; sz = 2'd2;
    case (op)
      6'h00: begin
        wr_addr = rd;
        case (fn)
          6'h20: begin wr_en = 1'b1; wr_data = sum_s; ov = add_ov(opa_s, opb_s, sum_s); end
          6'h22: begin wr_en = 1'b1; wr_data = dif_s; ov = sub_ov(opa_s, opb_s, dif_s); end
          6'h24: begin wr_en = 1'b1; wr_data = rs_v & rt_v; end
          6'h25: begin wr_en = 1'b1; wr_data = rs_v | rt_v; end
          6'h2A: begin wr_en = 1'b1; wr_data = {31'h0, opa_s < opb_s}; end
          6'h2B: begin wr_en = 1'b1; wr_data = {31'h0, rs_v < rt_v}; end
          6'h08: npc = rs_v;
          6'h0C: sysc = 1'b1;
          6'h00: begin wr_en = 1'b1; wr_data = rt_v << sa; end
          default: ri = 1'b1;
        endcase
      end
      6'h08: begin wr_en = 1'b1; wr_data = sum_s; ov = add_ov(opa_s, opb_s, sum_s); end
      6'h0C: begin wr_en = 1'b1; wr_data = rs_v & zimm; end
      6'h0D: begin wr_en = 1'b1; wr_data = rs_v | zimm; end
      6'h0F: begin wr_en = 1'b1; wr_data = {i_inst_rdata[15:0], 16'h0}; end
      6'h04: if (rs_v == rt_v) npc = pc4 + {simm[29:0], 2'b00};
      6'h05: if (rs_v != rt_v) npc = pc4 + {simm[29:0], 2'b00};
      6'h23: begin ld = 1'b1; sz = 2'd2; end
      6'h21: begin ld = 1'b1; sz = 2'd1; end
      6'h20: begin ld = 1'b1; sz = 2'd0; end
      6'h2B: begin st = 1'b1; sz = 2'd2; end
      6'h29: begin st = 1'b1; sz = 2'd1; end
      6'h28: begin st = 1'b1; sz = 2'd0; end
      6'h02: npc = {pc4[31:28], i_inst_rdata[25:0], 2'b00};
      6'h03: begin
        npc = {pc4[31:28], i_inst_rdata[25:0], 2'b00};
        wr_en = 1'b1; wr_addr = 5'd31; wr_data = pc4;
      end
      6'h10: begin
        case (rs)
          5'h00: begin wr_en = 1'b1; wr_data = cp0_rd; end
          5'h04: mtc0 = 1'b1;
          5'h10: if (fn == 6'h18) begin eret = 1'b1; npc = epc_q; end else ri = 1'b1;
          default: ri = 1'b1;
        endcase
      end
      default: ri = 1'b1;
    endcase
  end

  // Address decode, load lane extraction and store lane steering
  logic        in_ram, in_int, mis, data_err, fetch_err, int_take, exc;
  logic [4:0]  exc_code;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [3:0]  be;
  logic [31:0] ld_v;

  assign in_ram    = maddr < 32'h0000_3000;
  assign in_int    = (maddr >= 32'h0000_7F20) && (maddr <= 32'h0000_7F23);
  assign mis       = ((sz == 2'd2) && (maddr[1:0] != 2'b00)) || ((sz == 2'd1) && maddr[0]);
  assign data_err  = (ld | st) && (mis || !(in_ram || in_int));
  assign fetch_err = (pc_q[1:0] != 2'b00) || (pc_q < 32'h0000_3000) || (pc_q > 32'h0000_6FFF);
  assign int_take  = interrupt & sr_q[10] & sr_q[0] & ~sr_q[1];

  always_comb begin
    exc = 1'b1;
    if (int_take)       exc_code = 5'd0;
    else if (fetch_err) exc_code = 5'd4;
    else if (ri)        exc_code = 5'd10;
    else if (sysc)      exc_code = 5'd8;
    else if (ov)        exc_code = 5'd12;
    else if (data_err)  exc_code = st ? 5'd5 : 5'd4;
    else begin          exc_code = 5'd0; exc = 1'b0; end
  end

  always_comb begin
    case (maddr[1:0])
      2'd0:    ld_b = m_data_rdata[7:0];
      2'd1:    ld_b = m_data_rdata[15:8];
      2'd2:    ld_b = m_data_rdata[23:16];
      default: ld_b = m_data_rdata[31:24];
    endcase
    ld_h = maddr[1] ? m_data_rdata[31:16] : m_data_rdata[15:0];
    case (sz)
      2'd0:    ld_v = {{24{ld_b[7]}}, ld_b};
      2'd1:    ld_v = {{16{ld_h[15]}}, ld_h};
      default: ld_v = m_data_rdata;
    endcase
    if (in_int) ld_v = 32'h0;
    case (sz)
      2'd0:    begin be = 4'b0001 << maddr[1:0]; m_data_wdata = {4{rt_v[7:0]}}; end
      2'd1:    begin be = maddr[1] ? 4'b1100 : 4'b0011; m_data_wdata = {2{rt_v[15:0]}}; end
      default: begin be = 4'b1111; m_data_wdata = rt_v; end
    endcase
  end

  assign macroscopic_pc = pc_q;
  assign i_inst_addr    = pc_q;
  assign m_inst_addr    = pc_q;
  assign w_inst_addr    = pc_q;
  assign m_data_addr    = maddr;
  assign m_int_addr     = maddr;
  assign m_data_byteen  = (reset && st && !exc && in_ram) ? be : 4'b0000;
  assign m_int_byteen   = (reset && st && !exc && in_int) ? be : 4'b0000;
  assign w_grf_we       = reset && wr_en && (wr_addr != 5'd0) && !exc;
  assign w_grf_addr     = wr_addr;
  assign w_grf_wdata    = ld ? ld_v : wr_data;
  assign pc_d           = exc ? HANDLER_PC : npc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q  <= RESET_PC;
      sr_q  <= 32'h0;
      epc_q <= 32'h0;
      exc_q <= 5'd0;
      ip_q  <= 1'b0;
      for (int i = 0; i < 32; i++) grf_q[i] <= 32'h0;
    end else begin
      pc_q <= pc_d;
      ip_q <= interrupt;
      if (exc) begin
        epc_q    <= pc_q;
        exc_q    <= exc_code;
        sr_q[1]  <= 1'b1;
      end else if (mtc0) begin
        if (rd == 5'd12) sr_q  <= rt_v & 32'h0000_FC03;
        if (rd == 5'd14) epc_q <= rt_v;
      end else if (eret) begin
        sr_q[1] <= 1'b0;
      end
      if (w_grf_we) grf_q[wr_addr] <= w_grf_wdata;
    end
  end
endmodule

// File: tb/tb_mips_cpu_core.sv
// Directed bench for mips_cpu_core: instructions are driven straight onto the
// fetch port and CP0 state is read back through mfc0.
module tb_mips_cpu_core;
  logic        clk = 1'b0;
  logic        reset, interrupt;
  logic [31:0] macroscopic_pc, i_inst_addr, i_inst_rdata, m_data_addr, m_data_rdata;
  logic [31:0] m_data_wdata, m_int_addr, m_inst_addr, w_grf_wdata, w_inst_addr;
  logic [3:0]  m_data_byteen, m_int_byteen;
  logic        w_grf_we;
  logic [4:0]  w_grf_addr;
  int total = 0;
  int bad = 0;

  mips_cpu_core dut (
    .clk(clk), .reset(reset), .interrupt(interrupt),
    .macroscopic_pc(macroscopic_pc), .i_inst_addr(i_inst_addr), .i_inst_rdata(i_inst_rdata),
    .m_data_addr(m_data_addr), .m_data_rdata(m_data_rdata), .m_data_wdata(m_data_wdata),
    .m_data_byteen(m_data_byteen), .m_int_addr(m_int_addr), .m_int_byteen(m_int_byteen),
    .m_inst_addr(m_inst_addr), .w_grf_we(w_grf_we), .w_grf_addr(w_grf_addr),
    .w_grf_wdata(w_grf_wdata), .w_inst_addr(w_inst_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] inst, input logic [31:0] rdata);
    i_inst_rdata = inst;
    m_data_rdata = rdata;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; interrupt = 1'b0; i_inst_rdata = 32'h0; m_data_rdata = 32'h0;
    tick(); tick();
    drive(32'hAC000000, 32'h0);                       // sw $0,0($0) held in reset
    chk("rst_pc", i_inst_addr, 32'h3000);
    chk("rst_we", {31'h0, w_grf_we}, 32'h0);
    chk("rst_be", {28'h0, m_data_byteen}, 32'h0);
    chk("rst_ibe", {28'h0, m_int_byteen}, 32'h0);
    reset = 1'b1;

    drive(32'h34011234, 32'h0);                       // ori $1,$0,0x1234
    chk("ori_we", {31'h0, w_grf_we}, 32'h1);
    chk("ori_addr", {27'h0, w_grf_addr}, 32'd1);
    chk("ori_data", w_grf_wdata, 32'h00001234);
    chk("ori_iaddr", w_inst_addr, 32'h3000);
    tick();
    drive(32'h3C028000, 32'h0);                       // lui $2,0x8000
    chk("lui_addr", {27'h0, w_grf_addr}, 32'd2);
    chk("lui_data", w_grf_wdata, 32'h80000000);
    tick();
    drive(32'h2043FFFF, 32'h0);                       // addi $3,$2,-1 -> Ov
    chk("ov_pc", i_inst_addr, 32'h3008);
    chk("ov_we", {31'h0, w_grf_we}, 32'h0);
    tick();
    drive(32'h40057000, 32'h0);                       // mfc0 $5,EPC
    chk("ov_hpc", i_inst_addr, 32'h4180);
    chk("ov_epc", w_grf_wdata, 32'h3008);
    tick();
    drive(32'h40066800, 32'h0);                       // mfc0 $6,Cause
    chk("ov_cause", w_grf_wdata, 32'h00000030);
    tick();
    drive(32'h40076000, 32'h0);                       // mfc0 $7,SR
    chk("ov_sr", w_grf_wdata, 32'h00000002);
    tick();
    drive(32'h42000018, 32'h0);                       // eret
    chk("eret_we", {31'h0, w_grf_we}, 32'h0);
    tick();

    drive(32'hA0010001, 32'h0);                       // sb $1,1($0)
    chk("sb_pc", i_inst_addr, 32'h3008);
    chk("sb_be", {28'h0, m_data_byteen}, 32'h2);
    chk("sb_wd", m_data_wdata, 32'h34343434);
    chk("sb_addr", m_data_addr, 32'h1);
    chk("sb_we", {31'h0, w_grf_we}, 32'h0);
    tick();
    drive(32'h80040001, 32'h00003400);                // lb $4,1($0)
    chk("lb_data", w_grf_wdata, 32'h00000034);
    chk("lb_addr", {27'h0, w_grf_addr}, 32'd4);
    tick();
    drive(32'h84080002, 32'h9ABC0000);                // lh $8,2($0)
    chk("lh_data", w_grf_wdata, 32'hFFFF9ABC);
    tick();
    drive(32'h10210002, 32'h0);                       // beq $1,$1,+2 at 3014
    chk("beq_we", {31'h0, w_grf_we}, 32'h0);
    tick();
    drive(32'h0C000C10, 32'h0);                       // jal 0x3040
    chk("beq_tgt", i_inst_addr, 32'h3020);
    chk("jal_addr", {27'h0, w_grf_addr}, 32'd31);
    chk("jal_data", w_grf_wdata, 32'h3024);
    tick();
    drive(32'h14000005, 32'h0);                       // bne $0,$0 not taken
    chk("jal_tgt", i_inst_addr, 32'h3040);
    tick();
    drive(32'hA4010002, 32'h0);                       // sh $1,2($0)
    chk("bne_nt", i_inst_addr, 32'h3044);
    chk("sh_be", {28'h0, m_data_byteen}, 32'hC);
    chk("sh_wd", m_data_wdata, 32'h12341234);
    tick();
    drive(32'h00214820, 32'h0);                       // add $9,$1,$1
    chk("add_data", w_grf_wdata, 32'h2468);
    tick();
    drive(32'h0041502A, 32'h0);                       // slt $10,$2,$1
    chk("slt_data", w_grf_wdata, 32'h1);
    tick();
    drive(32'h0041582B, 32'h0);                       // sltu $11,$2,$1
    chk("sltu_data", w_grf_wdata, 32'h0);
    chk("sltu_we", {31'h0, w_grf_we}, 32'h1);
    tick();
    drive(32'h340C0401, 32'h0);                       // ori $12,$0,0x401
    tick();
    drive(32'h408C6000, 32'h0);                       // mtc0 $12,SR
    chk("mtc0_we", {31'h0, w_grf_we}, 32'h0);
    tick();

    interrupt = 1'b1;
    drive(32'h340D0005, 32'h0);                       // ori $13 hit by interrupt
    chk("int_pc", i_inst_addr, 32'h305C);
    chk("int_we", {31'h0, w_grf_we}, 32'h0);
    tick();
    drive(32'hAC007F20, 32'h0);                       // sw $0,0x7F20($0)
    chk("int_hpc", i_inst_addr, 32'h4180);
    chk("ack_ibe", {28'h0, m_int_byteen}, 32'hF);
    chk("ack_dbe", {28'h0, m_data_byteen}, 32'h0);
    chk("ack_addr", m_int_addr, 32'h7F20);
    tick();
    drive(32'h40057000, 32'h0);
    chk("int_epc", w_grf_wdata, 32'h305C);
    tick();
    drive(32'h40066800, 32'h0);
    chk("int_cause", w_grf_wdata, 32'h00000400);
    tick();
    interrupt = 1'b0;
    drive(32'h42000018, 32'h0);                       // eret
    tick();
    drive(32'h40076000, 32'h0);                       // mfc0 $7,SR
    chk("eret_pc", i_inst_addr, 32'h305C);
    chk("eret_sr", w_grf_wdata, 32'h00000401);
    tick();

    drive(32'h8C0E3000, 32'h0);                       // lw $14,0x3000($0) -> AdEL
    chk("adel_we", {31'h0, w_grf_we}, 32'h0);
    chk("adel_be", {28'h0, m_data_byteen}, 32'h0);
    tick();
    drive(32'h40066800, 32'h0);
    chk("adel_cause", w_grf_wdata, 32'h00000010);
    tick();
    drive(32'hFC000000, 32'h0);                       // opcode 0x3F -> RI
    chk("ri_we", {31'h0, w_grf_we}, 32'h0);
    tick();
    drive(32'h40066800, 32'h0);
    chk("ri_pc", i_inst_addr, 32'h4180);
    chk("ri_cause", w_grf_wdata, 32'h00000028);
    tick();
    drive(32'h0000000C, 32'h0);                       // syscall
    tick();
    drive(32'h40066800, 32'h0);
    chk("sys_cause", w_grf_wdata, 32'h00000020);
    tick();
    drive(32'hAC003000, 32'h0);                       // sw $0,0x3000($0) -> AdES
    chk("ades_be", {28'h0, m_data_byteen}, 32'h0);
    tick();
    drive(32'h40066800, 32'h0);
    chk("ades_cause", w_grf_wdata, 32'h00000014);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
